// File: rtl/pal_cfg_loader.sv
// Configuration writer for the PAL fabric.
// Accepts configuration bytes over a valid/ready handshake and serialises
// them MSB-first onto the PAL configuration shift chain, one bit per clock,
// qualified by CFG_SHIFT_EN. Exactly SR_LEN bits are shifted per load.
module pal_cfg_loader #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int P = 8
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic       START,
  input  logic [7:0] DATA_IN,
  input  logic       DATA_VALID,
  output logic       DATA_READY,
  output logic       CFG_OUT,
  output logic       CFG_SHIFT_EN,
  output logic       BUSY,
  output logic       DONE
);

  localparam int SR_LEN = 2*N*P + P*M;
  localparam int NBYTES = (SR_LEN + 7) / 8;
  localparam int BW     = $clog2(SR_LEN + 1);
  localparam int CW     = $clog2(NBYTES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]    state;
  logic [7:0]    shreg;
  logic [3:0]    rem;
  logic [7:0]    hold;
  logic          hold_full;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] byte_cnt;

  logic in_load;
  logic shift_en;
  logic take;
  logic last_bit;

  // Handshake, shift qualification and status decode
  always_comb begin
    in_load      = (state == S_LOAD);
    shift_en     = in_load && (rem != 4'd0);
    DATA_READY   = in_load && !hold_full && (byte_cnt < CW'(NBYTES));
    take         = DATA_VALID && DATA_READY;
    last_bit     = shift_en && (bit_cnt == BW'(SR_LEN - 1));
    CFG_SHIFT_EN = shift_en;
    CFG_OUT      = shift_en & shreg[7];
    BUSY         = in_load;
    DONE         = (state == S_FINISH);
  end

  // Control FSM, byte buffering and serialiser
  always_ff @(posedge CLK) begin
    if (!RES_N) begin
      state     <= S_IDLE;
      shreg     <= '0;
      rem       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            state     <= S_LOAD;
            rem       <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
          end
        end
        S_LOAD: begin
          if (take)
            byte_cnt <= byte_cnt + CW'(1);
          if (shift_en)
            bit_cnt <= bit_cnt + BW'(1);
          if (last_bit) begin
            // Leftover low bits of a partial final byte are dropped here.
            state     <= S_FINISH;
            rem       <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
          end else if (rem == 4'd0) begin
            // Serialiser idle: refill from the buffer, or take the incoming
            // byte directly so its first bit appears on the next cycle.
            if (hold_full) begin
              shreg     <= hold;
              rem       <= 4'd8;
              hold_full <= 1'b0;
            end else if (take) begin
              shreg <= DATA_IN;
              rem   <= 4'd8;
            end
          end else begin
            if (rem == 4'd1 && hold_full) begin
              shreg     <= hold;
              rem       <= 4'd8;
              hold_full <= 1'b0;
            end else begin
              shreg <= {shreg[6:0], 1'b0};
              rem   <= rem - 4'd1;
            end
            if (take) begin
              hold      <= DATA_IN;
              hold_full <= 1'b1;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Self-checking bench for pal_cfg_loader: default 192-bit chain plus a
// 15-bit chain instance for the partial-final-byte case.
module tb_pal_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default-size DUT
  logic       res_n, start, data_valid;
  logic [7:0] data_in;
  logic       data_ready, cfg_out, cfg_shift_en, busy, done;

  pal_cfg_loader u_dut (
    .CLK(clk), .RES_N(res_n), .START(start), .DATA_IN(data_in),
    .DATA_VALID(data_valid), .DATA_READY(data_ready), .CFG_OUT(cfg_out),
    .CFG_SHIFT_EN(cfg_shift_en), .BUSY(busy), .DONE(done)
  );

  // Small DUT: SR_LEN = 2*2*3 + 3*1 = 15, NBYTES = 2
  logic       s_res_n, s_start, s_data_valid;
  logic [7:0] s_data_in;
  logic       s_data_ready, s_cfg_out, s_cfg_shift_en, s_busy, s_done;

  pal_cfg_loader #(.N(2), .M(1), .P(3)) u_small (
    .CLK(clk), .RES_N(s_res_n), .START(s_start), .DATA_IN(s_data_in),
    .DATA_VALID(s_data_valid), .DATA_READY(s_data_ready), .CFG_OUT(s_cfg_out),
    .CFG_SHIFT_EN(s_cfg_shift_en), .BUSY(s_busy), .DONE(s_done)
  );

  // Model of the PAL chain plus event bookkeeping, sampled mid-cycle
  logic [191:0] chain = '0;
  int cyc = 0, total_en = 0, fall = 0, done_total = 0;
  int last_en_cyc = 0, done_cyc = 0, idle_dirty = 0;
  logic prev_en = 1'b0, done_busy = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cfg_shift_en) begin
      total_en    = total_en + 1;
      chain       = {chain[190:0], cfg_out};
      last_en_cyc = cyc;
    end else if (cfg_out) begin
      idle_dirty = idle_dirty + 1;
    end
    if (prev_en && !cfg_shift_en && busy)
      fall = fall + 1;
    prev_en = cfg_shift_en;
    if (done) begin
      done_total = done_total + 1;
      done_cyc   = cyc;
      done_busy  = busy | cfg_shift_en;
    end
  end

  logic [14:0] s_chain = '0;
  int s_total_en = 0, s_done_total = 0;
  logic s_last = 1'b1;

  always @(negedge clk) begin
    if (s_cfg_shift_en) begin
      s_total_en = s_total_en + 1;
      s_chain    = {s_chain[13:0], s_cfg_out};
      s_last     = s_cfg_out;
    end
    if (s_done)
      s_done_total = s_done_total + 1;
  end

  logic [7:0] bq [24];

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one byte and hold it until the DUT takes it
  task automatic feed_byte(input logic [7:0] b, input bit pulse_start);
    int w = 0;
    data_in    = b;
    data_valid = 1'b1;
    if (pulse_start) start = 1'b1;
    do begin
      @(negedge clk);
      w++;
    end while (!data_ready && w < 200);
    if (!data_ready) begin
      check("feed_timeout", 0, 1);
      data_valid = 1'b0;
      start      = 1'b0;
      return;
    end
    @(posedge clk); #1;
    data_valid = 1'b0;
    start      = 1'b0;
  endtask

  // mode: 0 = must be gapless, 1 = must underrun, 2 = either
  task automatic do_load(input int fixed_gap, input int gap_max, input int restart_at,
                         input int mode);
    int en0   = total_en;
    int fall0 = fall;
    int done0 = done_total;
    int w     = 0;
    int gap;
    logic [191:0] exp = '0;
    for (int i = 0; i < 24; i++) exp = {exp[183:0], bq[i]};

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ready_after_start", data_ready, 1);

    for (int i = 0; i < 24; i++) begin
      feed_byte(bq[i], restart_at == i);
      gap = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(gap_max, 0));
      repeat (gap) @(posedge clk);
      #1;
    end

    while (done_total == done0 && w < 400) begin
      @(negedge clk); #1;
      w++;
    end
    check("done_seen", done_total != done0, 1);
    check("bit_count", total_en - en0, 192);
    check("chain", chain, exp);
    check("done_latency", done_cyc, last_en_cyc + 1);
    check("busy_at_done", done_busy, 0);
    if (mode == 0) check("gapless", fall - fall0, 0);
    if (mode == 1) check("underrun_seen", (fall - fall0) != 0, 1);
    @(posedge clk); #1;
    check("done_pulse_end", {done, busy, cfg_shift_en}, 3'b000);
    check("done_pulses", done_total - done0, 1);
  endtask

  task automatic rand_bytes();
    for (int i = 0; i < 24; i++) bq[i] = 8'($urandom);
  endtask

  task automatic seq_bytes();
    bq[0] = 8'hA5;
    for (int i = 1; i < 24; i++) bq[i] = 8'(i);
  endtask

  initial begin
    int w;
    int en0;
    int rdy_hi;
    logic [7:0] sb [2];
    res_n = 1'b0; start = 1'b0; data_valid = 1'b0; data_in = '0;
    s_res_n = 1'b0; s_start = 1'b0; s_data_valid = 1'b0; s_data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {cfg_out, cfg_shift_en, data_ready, busy, done}, 5'b0);
    res_n   = 1'b1;
    s_res_n = 1'b1;
    @(posedge clk); #1;

    // Bytes offered in IDLE are refused
    data_valid = 1'b1;
    data_in    = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_refuse", {data_ready, busy, cfg_shift_en}, 3'b000);
    end
    @(posedge clk); #1;
    data_valid = 1'b0;

    // Gapless default load with a known pattern
    seq_bytes();
    do_load(0, 0, -1, 0);
    check("chain_msb", chain[191], 1);
    check("chain_low_byte", chain[7:0], 8'h17);

    // Back-to-back: START on the first IDLE cycle after DONE
    rand_bytes();
    do_load(0, 0, -1, 0);

    // Slow host forces underruns; chain content must still match
    seq_bytes();
    do_load(10, 0, -1, 1);
    check("underrun_chain_msb", chain[191], 1);
    check("underrun_chain_low", chain[7:0], 8'h17);

    // START re-pulsed mid-load must not restart anything
    rand_bytes();
    do_load(-1, 3, 10, 2);

    // Reset after ~50 bits, then a full fresh load
    rand_bytes();
    en0   = total_en;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) feed_byte(bq[i], 1'b0);
    w = 0;
    while (total_en - en0 < 50 && w < 200) begin
      @(negedge clk); #1;
      w++;
    end
    check("reached_50_bits", (total_en - en0) >= 50, 1);
    res_n = 1'b0;
    @(posedge clk); #1;
    check("midload_reset", {cfg_out, cfg_shift_en, data_ready, busy, done}, 5'b0);
    res_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {busy, data_ready, done}, 3'b000);
    rand_bytes();
    do_load(-1, 2, -1, 2);

    // Two more randomized loads with random host gaps
    for (int k = 0; k < 2; k++) begin
      rand_bytes();
      do_load(-1, 8, -1, 2);
    end

    // 15-bit chain: only the top 7 bits of the second byte are shifted
    sb[0] = 8'hFF;
    sb[1] = 8'h80;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_data_in    = sb[i];
      s_data_valid = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!s_data_ready && w < 100);
      check("small_feed", s_data_ready, 1);
      @(posedge clk); #1;
    end
    s_data_in = 8'h55;
    rdy_hi = 0;
    w = 0;
    while (s_done_total == 0 && w < 100) begin
      @(negedge clk); #1;
      if (s_data_ready) rdy_hi++;
      w++;
    end
    s_data_valid = 1'b0;
    check("small_done", s_done_total, 1);
    check("small_bits", s_total_en, 15);
    check("small_chain", s_chain, 15'h7FC0);
    check("small_last_bit", s_last, 0);
    check("small_no_extra_ready", rdy_hi, 0);

    check("idle_cfg_out_clean", idle_dirty, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
